// File: rtl/common_p.sv
// Shared clock-domain bundle type used by the measurement-path blocks.
package common_p;

    typedef struct packed {
        logic clk;
        logic clk_en;
        logic sync_rst;
    } clk_dom_s;

endpackage

// File: rtl/multi_value_prioritizer.sv
// multi_value_prioritizer: tracks up to CANDIDATE_COUNT distinct written values
// with saturating grow/decay counters and reports the most persistent one.
// Optional macro MULTI_VALUE_PRIORITIZER_HYSTERESIS_EN adds hysteresis_i, a
// margin the leader must exceed before the prioritized slot switches.
module multi_value_prioritizer #(
    parameter int VALUE_BIT_WIDTH = 8,
    parameter int COUNT_BIT_WIDTH = 8,
    parameter int CANDIDATE_COUNT = 4,
    localparam int INDEX_BIT_WIDTH = $clog2(CANDIDATE_COUNT)
) (
    input  common_p::clk_dom_s          sys_dom_i,
    input  logic                        clear_state_i,
    input  logic [COUNT_BIT_WIDTH-1:0]  growth_rate_i,
    input  logic [COUNT_BIT_WIDTH-1:0]  decay_rate_i,
    input  logic [COUNT_BIT_WIDTH-1:0]  saturation_limit_i,
    input  logic [COUNT_BIT_WIDTH-1:0]  plateau_limit_i,
`ifdef MULTI_VALUE_PRIORITIZER_HYSTERESIS_EN
    input  logic [COUNT_BIT_WIDTH-1:0]  hysteresis_i,
`endif
    input  logic                        we_i,
    input  logic [VALUE_BIT_WIDTH-1:0]  data_i,
    output logic [CANDIDATE_COUNT-1:0]  candidate_valid_o,
    output logic [INDEX_BIT_WIDTH-1:0]  prioritized_index_o,
    output logic [COUNT_BIT_WIDTH-1:0]  prioritized_count_o,
    output logic                        locked_in_o,
    output logic [VALUE_BIT_WIDTH-1:0]  data_o
);

    logic                        clk;
    logic                        event_w;
    logic [COUNT_BIT_WIDTH-1:0]  hyst_w;

    logic [CANDIDATE_COUNT-1:0]  valid_q, valid_d;
    logic [VALUE_BIT_WIDTH-1:0]  value_q [CANDIDATE_COUNT];
    logic [VALUE_BIT_WIDTH-1:0]  value_d [CANDIDATE_COUNT];
    logic [COUNT_BIT_WIDTH-1:0]  count_q [CANDIDATE_COUNT];
    logic [COUNT_BIT_WIDTH-1:0]  count_d [CANDIDATE_COUNT];
    logic [INDEX_BIT_WIDTH-1:0]  prio_q, prio_d;
    logic [COUNT_BIT_WIDTH-1:0]  plateau_q, plateau_d;

    logic [CANDIDATE_COUNT-1:0]  match_vec;
    logic                        any_match;
    logic                        free_found;
    logic [INDEX_BIT_WIDTH-1:0]  free_idx;
    logic                        leader_found;
    logic [INDEX_BIT_WIDTH-1:0]  leader_idx;
    logic [COUNT_BIT_WIDTH-1:0]  leader_cnt;
    logic                        cur_valid;
    logic [COUNT_BIT_WIDTH-1:0]  cur_cnt;
    logic [COUNT_BIT_WIDTH:0]    switch_margin;
    logic                        switch_w;
    logic                        prio_valid;

    assign clk     = sys_dom_i.clk;
    assign event_w = sys_dom_i.clk_en && we_i && !clear_state_i;

`ifdef MULTI_VALUE_PRIORITIZER_HYSTERESIS_EN
    assign hyst_w = hysteresis_i;
`else
    assign hyst_w = '0;
`endif

    // Saturating add: sum formed one bit wider so it never wraps before clamping.
    function automatic logic [COUNT_BIT_WIDTH-1:0] sat_add(
        input logic [COUNT_BIT_WIDTH-1:0] a,
        input logic [COUNT_BIT_WIDTH-1:0] b,
        input logic [COUNT_BIT_WIDTH-1:0] lim
    );
        logic [COUNT_BIT_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[COUNT_BIT_WIDTH-1:0];
    endfunction

    // Find the matching slot and the lowest-index free slot (pre-update view).
    always_comb begin
        match_vec  = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < CANDIDATE_COUNT; i++) begin
            match_vec[i] = valid_q[i] && (value_q[i] == data_i);
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = INDEX_BIT_WIDTH'(i);
            end
        end
        any_match = |match_vec;
    end

    // Per-slot next state: grow the match, decay the rest, allocate on a miss.
    always_comb begin
        valid_d = valid_q;
        for (int unsigned i = 0; i < CANDIDATE_COUNT; i++) begin
            value_d[i] = value_q[i];
            count_d[i] = count_q[i];
            if (event_w) begin
                if (match_vec[i]) begin
                    count_d[i] = sat_add(count_q[i], growth_rate_i, saturation_limit_i);
                end else if (valid_q[i]) begin
                    count_d[i] = (count_q[i] <= decay_rate_i) ? '0 : count_q[i] - decay_rate_i;
                    valid_d[i] = (count_d[i] != '0);
                end else if (!any_match && free_found && (free_idx == INDEX_BIT_WIDTH'(i))) begin
                    valid_d[i] = 1'b1;
                    value_d[i] = data_i;
                    count_d[i] = sat_add('0, growth_rate_i, saturation_limit_i);
                end
            end
        end
    end

    // Leader selection over post-update counts (ties resolve to lowest index).
    always_comb begin
        leader_found = 1'b0;
        leader_idx   = '0;
        leader_cnt   = '0;
        for (int unsigned i = 0; i < CANDIDATE_COUNT; i++) begin
            if (valid_d[i] && (!leader_found || (count_d[i] > leader_cnt))) begin
                leader_found = 1'b1;
                leader_idx   = INDEX_BIT_WIDTH'(i);
                leader_cnt   = count_d[i];
            end
        end
    end

    // Switch decision and plateau counter update.
    always_comb begin
        cur_valid     = valid_d[prio_q];
        cur_cnt       = count_d[prio_q];
        switch_margin = {1'b0, cur_cnt} + {1'b0, hyst_w};
        switch_w      = !cur_valid || ({1'b0, leader_cnt} > switch_margin);
        prio_d        = switch_w ? leader_idx : prio_q;
        if (switch_w) begin
            plateau_d = '0;
        end else if (cur_cnt == saturation_limit_i) begin
            plateau_d = (plateau_q >= plateau_limit_i) ? plateau_limit_i : plateau_q + 1'b1;
        end else begin
            plateau_d = '0;
        end
    end

    // State registers: sync_rst beats clear, clear beats a write.
    always_ff @(posedge clk) begin
        if (sys_dom_i.sync_rst || (sys_dom_i.clk_en && clear_state_i)) begin
            valid_q   <= '0;
            prio_q    <= '0;
            plateau_q <= '0;
            for (int unsigned i = 0; i < CANDIDATE_COUNT; i++) begin
                value_q[i] <= '0;
                count_q[i] <= '0;
            end
        end else if (event_w) begin
            valid_q   <= valid_d;
            prio_q    <= prio_d;
            plateau_q <= plateau_d;
            for (int unsigned i = 0; i < CANDIDATE_COUNT; i++) begin
                value_q[i] <= value_d[i];
                count_q[i] <= count_d[i];
            end
        end
    end

    // Output decode from the prioritized slot; zero when that slot is empty.
    always_comb begin
        prio_valid          = valid_q[prio_q];
        candidate_valid_o   = valid_q;
        prioritized_index_o = prio_q;
        data_o              = prio_valid ? value_q[prio_q] : '0;
        prioritized_count_o = prio_valid ? count_q[prio_q] : '0;
        locked_in_o         = prio_valid && (plateau_q >= plateau_limit_i)
                              && (count_q[prio_q] == saturation_limit_i);
    end

endmodule
